scu_dsp_dma_resp: RTL

- Responder (SCU side) for the DSP's internal DMA channel.
- Latches the read/write base addresses and the DMA instruction word from the DSP D1-bus strobes.
- Services each DSP word request (DMA_REQ) with one external memory-bus transaction, then returns a one-CE_R DMA_ACK.
- Signals completion with a DMA_END pulse, which the DSP detects as a falling edge.
- Sits between SCU_DSP and the SCU's internal A/B/C-bus arbiter port.

---
 rtl/scu_dsp_dma_resp.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/scu_dsp_dma_resp.sv
// rtl/scu_dsp_dma_resp.sv - SCU-side responder for the DSP internal DMA channel.
// Turns each DSP word request into one external bus transaction and handshakes back on CE_R.
module scu_dsp_dma_resp #(
  parameter int ADDR_W    = 27,
  parameter int INC_SCALE = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CE_R,
  input  logic              CE_F,
  input  logic [31:0]       DSO,
  input  logic              RA0W,
  input  logic              WA0W,
  input  logic              DMAW,
  input  logic              DMA_REQ,
  input  logic              DMA_RUN,
  input  logic              DMA_LAST,
  input  logic              DMA_WE,
  input  logic [31:0]       DMA_DO,
  output logic [31:0]       DMA_DI,
  output logic              DMA_ACK,
  output logic              DMA_END,
  output logic [ADDR_W-1:0] MEM_A,
  output logic [31:0]       MEM_DO,
  input  logic [31:0]       MEM_DI,
  output logic              MEM_WE,
  output logic              MEM_REQ,
  input  logic              MEM_ACK,
  output logic              BUSY
);

  typedef enum logic [2:0] {
    S_IDLE, S_CAP, S_BUS, S_ACK, S_NEXT, S_END
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ra0_q, ra0_d;
  logic [ADDR_W-1:0] wa0_q, wa0_d;
  logic [ADDR_W-1:0] inc_q, inc_d;
  logic              dir_q, dir_d;
  logic              lastf_q, lastf_d;
  logic              endc_q, endc_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       di_q, di_d;

  logic unused_dso;
  assign unused_dso = &{1'b0, DSO[31:ADDR_W-2]};

  // Add code 0 means a fixed address; codes 1..7 step 1,2,4,...,64 longwords.
  function automatic logic [7:0] add_lw(input logic [2:0] code);
    logic [7:0] r;
    r = 8'd0;
    if (code != 3'd0) r = 8'd1 << (code - 3'd1);
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    ra0_d   = ra0_q;
    wa0_d   = wa0_q;
    inc_d   = inc_q;
    dir_d   = dir_q;
    lastf_d = lastf_q;
    endc_d  = endc_q;
    wdata_d = wdata_q;
    di_d    = di_q;

    if (state_q == S_BUS && MEM_ACK) begin
      if (dir_q) begin
        wa0_d = wa0_q + inc_q;
      end else begin
        ra0_d = ra0_q + inc_q;
        di_d  = MEM_DI;
      end
    end

    // Register loads come after the advance so a coincident load wins.
    if (RA0W) ra0_d = {DSO[ADDR_W-3:0], 2'b00};
    if (WA0W) wa0_d = {DSO[ADDR_W-3:0], 2'b00};
    if (DMAW) inc_d = ADDR_W'(add_lw(DSO[17:15])) << INC_SCALE;

    case (state_q)
      S_IDLE: begin
        if (CE_R && DMA_RUN && DMA_REQ) begin
          dir_d   = DMA_WE;
          state_d = DMA_WE ? S_CAP : S_BUS;
        end
      end
      S_CAP: begin
        if (CE_R) begin
          wdata_d = DMA_DO;
          lastf_d = DMA_LAST;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        if (MEM_ACK) state_d = dir_q ? S_NEXT : S_ACK;
      end
      S_ACK: begin
        if (CE_R) begin
          lastf_d = DMA_LAST;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (CE_R) begin
          if (lastf_q)       state_d = S_END;
          else if (!DMA_RUN) state_d = S_IDLE;
          else if (DMA_REQ)  state_d = dir_q ? S_CAP : S_BUS;
        end
      end
      S_END: begin
        // Two CE_F samples in END: the DSP sees END high, then low after we leave.
        if (CE_F) begin
          if (endc_q) begin
            endc_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            endc_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_END) endc_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      ra0_q   <= '0;
      wa0_q   <= '0;
      inc_q   <= '0;
      dir_q   <= 1'b0;
      lastf_q <= 1'b0;
      endc_q  <= 1'b0;
      wdata_q <= '0;
      di_q    <= '0;
    end else begin
      state_q <= state_d;
      ra0_q   <= ra0_d;
      wa0_q   <= wa0_d;
      inc_q   <= inc_d;
      dir_q   <= dir_d;
      lastf_q <= lastf_d;
      endc_q  <= endc_d;
      wdata_q <= wdata_d;
      di_q    <= di_d;
    end
  end

  assign MEM_REQ = (state_q == S_BUS);
  assign MEM_A   = MEM_REQ ? (dir_q ? wa0_q : ra0_q) : '0;
  assign MEM_WE  = MEM_REQ & dir_q;
  assign MEM_DO  = (MEM_REQ && dir_q) ? wdata_q : 32'd0;
  assign DMA_ACK = (state_q == S_CAP) || (state_q == S_ACK);
  assign DMA_END = (state_q == S_END);
  assign DMA_DI  = di_q;
  assign BUSY    = (state_q != S_IDLE);

endmodule
